// File: rtl/pbit_pkg.sv
// Shared definitions for the p-bit sampler: sweep FSM encoding, field width
// and the index-width helper used by the controller and the field unit.
package pbit_pkg;

  localparam int FIELD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_NEXT   = 3'd4,
    ST_FIN    = 3'd5
  } sweep_state_e;

  // A single p-bit still needs a one-bit index so the address port never collapses.
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pbit_sweep_ctrl.sv
// Gibbs sweep sequencer: walks the p-bit index, waits out the field latency,
// consumes one RNG threshold per bit and writes the sampled bit back in place.
module pbit_sweep_ctrl
  import pbit_pkg::*;
#(
  parameter int PBITS     = 16,
  parameter int FIELD_LAT = 2,
  parameter int SWEEP_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [SWEEP_W-1:0]        num_sweeps,
  input  logic                      load_init,
  input  logic [PBITS-1:0]          init_state,
  input  logic                      rand_valid,
  input  logic signed [FIELD_W-1:0] rand_data,
  output logic                      rand_ready,
  input  logic signed [FIELD_W-1:0] field_in,
  output logic signed [FIELD_W-1:0] index_out,
  output logic [PBITS-1:0]          state_out,
  output logic                      busy,
  output logic                      done,
  output logic [SWEEP_W-1:0]        sweep_cnt
);

  localparam int IW = index_width(PBITS);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_ISSUE  = ST_ISSUE;
  localparam logic [2:0] S_WAIT   = ST_WAIT;
  localparam logic [2:0] S_SAMPLE = ST_SAMPLE;
  localparam logic [2:0] S_NEXT   = ST_NEXT;
  localparam logic [2:0] S_FIN    = ST_FIN;

  localparam logic [IW-1:0]      LAST_IDX  = IW'(PBITS - 1);
  localparam logic [2:0]         LAT_LOAD  = 3'(FIELD_LAT);
  localparam logic [SWEEP_W-1:0] SWEEP_ONE = SWEEP_W'(1);

  logic [2:0]         state;
  logic [IW-1:0]      idx;
  logic [2:0]         wait_cnt;
  logic [PBITS-1:0]   pbits_q;
  logic [SWEEP_W-1:0] sweeps_q;
  logic [SWEEP_W-1:0] sweep_q;
  logic               new_bit;
  logic               last_sweep;

  // Signed compare; a tie with the threshold samples 0.
  assign new_bit    = (field_in > rand_data);
  assign last_sweep = ((sweep_q + SWEEP_ONE) == sweeps_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      wait_cnt <= '0;
      pbits_q  <= '0;
      sweeps_q <= '0;
      sweep_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_init) begin
            pbits_q <= init_state;
          end
          if (start) begin
            sweeps_q <= num_sweeps;
            sweep_q  <= '0;
            idx      <= '0;
            state    <= (num_sweeps == '0) ? S_FIN : S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt <= LAT_LOAD;
          state    <= (FIELD_LAT == 0) ? S_SAMPLE : S_WAIT;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          if (wait_cnt == 3'd1) begin
            state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          if (rand_valid) begin
            pbits_q[idx] <= new_bit;
            state        <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (idx == LAST_IDX) begin
            idx     <= '0;
            sweep_q <= sweep_q + SWEEP_ONE;
            state   <= last_sweep ? S_FIN : S_ISSUE;
          end else begin
            idx   <= idx + IW'(1);
            state <= S_ISSUE;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // busy already drops in the FIN cycle so done and !busy coincide.
  assign busy       = (state != S_IDLE) && (state != S_FIN);
  assign done       = (state == S_FIN);
  assign rand_ready = (state == S_SAMPLE) && rand_valid;
  assign index_out  = {{(FIELD_W - IW){1'b0}}, idx};
  assign state_out  = pbits_q;
  assign sweep_cnt  = sweep_q;

endmodule

// File: tb/tb_pbit_sweep_ctrl.sv
// Directed bench for pbit_sweep_ctrl: a 16-bit/latency-2 instance for the main
// scenarios and a 5-bit instance for non-power-of-two index wrap.
module tb_pbit_sweep_ctrl;

  logic clk;
  logic rst;

  logic               start;
  logic [15:0]        num_sweeps;
  logic               load_init;
  logic [15:0]        init_state;
  logic               rand_valid;
  logic signed [31:0] rand_data;
  logic               rand_ready;
  logic signed [31:0] field_in;
  logic signed [31:0] index_out;
  logic [15:0]        state_out;
  logic               busy;
  logic               done;
  logic [15:0]        sweep_cnt;

  logic               start_b;
  logic [15:0]        num_b;
  logic               rand_ready_b;
  logic signed [31:0] index_b;
  logic [4:0]         state_b;
  logic               busy_b;
  logic               done_b;
  logic [15:0]        sweep_b;

  int n_checks;
  int n_pass;

  bit                 pattern_mode;
  logic signed [31:0] fld_tab [8];
  logic signed [31:0] thr_tab [8];
  logic [15:0]        exp_pat;

  pbit_sweep_ctrl #(.PBITS(16), .FIELD_LAT(2), .SWEEP_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_sweeps (num_sweeps),
    .load_init  (load_init),
    .init_state (init_state),
    .rand_valid (rand_valid),
    .rand_data  (rand_data),
    .rand_ready (rand_ready),
    .field_in   (field_in),
    .index_out  (index_out),
    .state_out  (state_out),
    .busy       (busy),
    .done       (done),
    .sweep_cnt  (sweep_cnt)
  );

  pbit_sweep_ctrl #(.PBITS(5), .FIELD_LAT(2), .SWEEP_W(16)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .start      (start_b),
    .num_sweeps (num_b),
    .load_init  (1'b0),
    .init_state (5'b0),
    .rand_valid (1'b1),
    .rand_data  (32'sd0),
    .rand_ready (rand_ready_b),
    .field_in   (32'sd1),
    .index_out  (index_b),
    .state_out  (state_b),
    .busy       (busy_b),
    .done       (done_b),
    .sweep_cnt  (sweep_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The field unit is modelled as a lookup on the issued index.
  always_comb begin
    field_in  = 32'sd5;
    rand_data = 32'sd0;
    if (pattern_mode) begin
      field_in  = fld_tab[index_out[2:0]];
      rand_data = thr_tab[index_out[2:0]];
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] nsw, input logic ld, input logic [15:0] init,
                               input int stall_idx, input int stall_len, input logic [15:0] stall_exp,
                               input int glitch_cyc, input int rst_cyc, input bit chk_bits,
                               output int cyc);
    int stall_pos;
    int pend_idx;
    bit pend;
    bit fin;
    bit aborted;
    stall_pos = -1;
    pend_idx  = 0;
    pend      = 0;
    fin       = 0;
    aborted   = 0;
    @(negedge clk);
    start      = 1'b1;
    load_init  = ld;
    init_state = init;
    num_sweeps = nsw;
    @(negedge clk);
    start      = 1'b0;
    load_init  = 1'b0;
    num_sweeps = 16'hFFFF;
    cyc = 1;
    while (!fin && !aborted && cyc < 3000) begin
      rand_valid = 1'b1;
      if (stall_idx >= 0) begin
        if (stall_pos < 0 && index_out == stall_idx) stall_pos = 0;
        if (stall_pos >= 3 && stall_pos < 3 + stall_len) rand_valid = 1'b0;
      end
      if (cyc == glitch_cyc) begin
        start      = 1'b1;
        load_init  = 1'b1;
        init_state = 16'h0000;
      end else begin
        start     = 1'b0;
        load_init = 1'b0;
      end
      #1;
      if (cyc == 1 && nsw != 16'd0) checkOutput("busy_in_run", busy, 1);
      if (pend) begin
        checkOutput("gibbs_bit", state_out[pend_idx], exp_pat[pend_idx]);
        pend = 0;
      end
      if (stall_pos >= 3 && stall_pos < 3 + stall_len)
        checkOutput("stall_hold", {index_out, state_out, rand_ready},
                    {32'(stall_idx), stall_exp, 1'b0});
      if (stall_idx >= 0 && stall_pos == 3 + stall_len) checkOutput("stall_release", rand_ready, 1);
      if (stall_idx >= 0 && stall_pos == 4 + stall_len)
        checkOutput("stall_update", state_out, stall_exp | 16'(1 << stall_idx));
      if (stall_pos >= 0) stall_pos++;
      if (chk_bits && rand_ready) begin
        pend     = 1;
        pend_idx = int'(index_out[3:0]);
      end
      if (cyc == rst_cyc) begin
        checkOutput("pre_rst_pos", {index_out[3:0], sweep_cnt}, {4'd9, 16'd1});
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("rst_regs", {state_out, sweep_cnt, index_out}, 64'd0);
        checkOutput("rst_flags", {busy, done, rand_ready}, 3'b000);
        rst     = 1'b0;
        aborted = 1;
      end else if (done) begin
        fin = 1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    rand_valid = 1'b1;
    start      = 1'b0;
    load_init  = 1'b0;
    if (!aborted) begin
      checkOutput("done_seen", fin, 1);
      checkOutput("busy_at_done", busy, 0);
    end
  endtask

  initial begin
    int cyc;
    int k;
    bit fin;
    n_checks     = 0;
    n_pass       = 0;
    pattern_mode = 0;
    fld_tab = '{-32'sd3, -32'sd3, 32'sd5, -32'sd5, 32'sh7FFFFFFF, 32'sh80000000, 32'sd0, 32'sd1};
    thr_tab = '{-32'sd3, -32'sd4, -32'sd5, 32'sd5, 32'sh80000000, 32'sh7FFFFFFF, 32'sd0, 32'sd0};
    exp_pat    = 16'hFFFF;
    rst        = 1'b1;
    start      = 1'b0;
    num_sweeps = 16'd0;
    load_init  = 1'b0;
    init_state = 16'h0000;
    rand_valid = 1'b1;
    start_b    = 1'b0;
    num_b      = 16'd0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_state", state_out, 16'h0000);
    checkOutput("reset_index", index_out, 0);
    checkOutput("reset_sweep", sweep_cnt, 0);
    checkOutput("reset_flags", {busy, done, rand_ready}, 3'b000);
    checkOutput("reset_b", {state_b, sweep_b, busy_b, done_b}, 0);

    @(negedge clk);
    load_init  = 1'b1;
    init_state = 16'hA5A5;
    @(negedge clk);
    load_init = 1'b0;
    #1;
    checkOutput("load_state", state_out, 16'hA5A5);
    checkOutput("load_idle", {busy, done, sweep_cnt}, 18'd0);

    // One sweep of +5 against 0; a start/load pulse mid-run must be ignored.
    exp_pat = 16'hFFFF;
    applyStimulus(16'd1, 1'b0, 16'h0, -1, 0, 16'h0, 20, -1, 1, cyc);
    checkOutput("single_len", cyc, 81);
    checkOutput("single_state", state_out, 16'hFFFF);
    checkOutput("single_sweeps", sweep_cnt, 16'd1);
    @(negedge clk);
    #1;
    checkOutput("done_pulse", {done, busy}, 2'b00);
    checkOutput("sweep_hold", sweep_cnt, 16'd1);

    // Equality and sign-sensitive thresholds per index.
    pattern_mode = 1;
    exp_pat      = 16'h9696;
    applyStimulus(16'd1, 1'b0, 16'h0, -1, 0, 16'h0, -1, -1, 1, cyc);
    checkOutput("pattern_len", cyc, 81);
    checkOutput("pattern_state", state_out, 16'h9696);
    pattern_mode = 0;

    applyStimulus(16'd0, 1'b0, 16'h0, -1, 0, 16'h0, -1, -1, 0, cyc);
    checkOutput("zero_len", cyc, 1);
    checkOutput("zero_state", state_out, 16'h9696);
    checkOutput("zero_sweeps", sweep_cnt, 16'd0);

    // Load and start together, then hold off the RNG for 7 cycles at index 4.
    exp_pat = 16'hFFFF;
    applyStimulus(16'd1, 1'b1, 16'h0000, 4, 7, 16'h000F, -1, -1, 1, cyc);
    checkOutput("stall_len", cyc, 88);
    checkOutput("stall_state", state_out, 16'hFFFF);

    applyStimulus(16'd3, 1'b1, 16'h0000, -1, 0, 16'h0, -1, 127, 0, cyc);
    applyStimulus(16'd1, 1'b0, 16'h0, -1, 0, 16'h0, -1, -1, 1, cyc);
    checkOutput("rerun_len", cyc, 81);
    checkOutput("rerun_state", state_out, 16'hFFFF);
    checkOutput("rerun_sweeps", sweep_cnt, 16'd1);

    // Five p-bits: index must wrap at 4, three sweeps of five 5-cycle bits.
    @(negedge clk);
    start_b = 1'b1;
    num_b   = 16'd3;
    @(negedge clk);
    start_b = 1'b0;
    cyc = 1;
    k   = 0;
    fin = 0;
    while (!fin && cyc < 1000) begin
      #1;
      if (rand_ready_b) begin
        checkOutput("b_index", index_b, k % 5);
        k++;
      end
      if (done_b) fin = 1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    checkOutput("b_done_seen", fin, 1);
    checkOutput("b_updates", k, 15);
    checkOutput("b_len", cyc, 76);
    checkOutput("b_sweeps", sweep_b, 16'd3);
    checkOutput("b_state", state_b, 5'h1F);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
